// File: rtl/dkong3_dma_seq_if.sv
// dkong3_dma_seq_if: trigger, bus-hold and RAM-port bundle for the sprite DMA.
// O_CSUM exists only when DKONG3_DMA_CSUM_EN is defined.
interface dkong3_dma_seq_if #(
  parameter int AW = 10
);
  logic          I_DMA_TRIG;
  logic          I_HLDA;
  logic [7:0]    I_DMA_DS;
  logic          O_HOLD;
  logic          O_BUSY;
  logic          O_DONE;
  logic [AW-1:0] O_DMA_AS;
  logic          O_DMA_CES;
  logic [AW-1:0] O_DMA_AD;
  logic [7:0]    O_DMA_DD;
  logic          O_DMA_CED;
`ifdef DKONG3_DMA_CSUM_EN
  logic [7:0]    O_CSUM;

  modport master (
    input  I_DMA_TRIG, I_HLDA, I_DMA_DS,
    output O_HOLD, O_BUSY, O_DONE,
    output O_DMA_AS, O_DMA_CES,
    output O_DMA_AD, O_DMA_DD, O_DMA_CED,
    output O_CSUM
  );

  modport slave (
    output I_DMA_TRIG, I_HLDA, I_DMA_DS,
    input  O_HOLD, O_BUSY, O_DONE,
    input  O_DMA_AS, O_DMA_CES,
    input  O_DMA_AD, O_DMA_DD, O_DMA_CED,
    input  O_CSUM
  );
`else
  modport master (
    input  I_DMA_TRIG, I_HLDA, I_DMA_DS,
    output O_HOLD, O_BUSY, O_DONE,
    output O_DMA_AS, O_DMA_CES,
    output O_DMA_AD, O_DMA_DD, O_DMA_CED
  );

  modport slave (
    output I_DMA_TRIG, I_HLDA, I_DMA_DS,
    input  O_HOLD, O_BUSY, O_DONE,
    input  O_DMA_AS, O_DMA_CES,
    input  O_DMA_AD, O_DMA_DD, O_DMA_CED
  );
`endif
endinterface

// File: rtl/dkong3_dma_seq.sv
// dkong3_dma_seq: bus-hold sprite DMA, work RAM -> object RAM, 1 byte/clock.
// Optional DKONG3_DMA_CSUM_EN adds a mod-256 checksum of the last transfer.
module dkong3_dma_seq #(
  parameter int            XFER_LEN = 415,
  parameter int            AW       = 10,
  parameter logic [AW-1:0] SRC_BASE = '0,
  parameter logic [AW-1:0] DST_BASE = '0
) (
  input logic              I_CLK,
  input logic              I_RESET,
  dkong3_dma_seq_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RUN,
    DONE
  } state_t;

  localparam int            CW   = 11;
  localparam logic [CW-1:0] LEN  = CW'(XFER_LEN);
  localparam logic [CW-1:0] LAST = CW'(XFER_LEN + 1);

  state_t        state;
  logic          trig_d;
  logic          pend;
  logic          rd_v;
  logic [CW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          start;

  assign start = bus.I_DMA_TRIG & ~trig_d;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state         <= IDLE;
      trig_d        <= 1'b1;
      pend          <= 1'b0;
      rd_v          <= 1'b0;
      rd_idx        <= '0;
      wr_idx        <= '0;
      bus.O_HOLD    <= 1'b0;
      bus.O_BUSY    <= 1'b0;
      bus.O_DONE    <= 1'b0;
      bus.O_DMA_AS  <= '0;
      bus.O_DMA_CES <= 1'b0;
      bus.O_DMA_AD  <= '0;
      bus.O_DMA_DD  <= '0;
      bus.O_DMA_CED <= 1'b0;
    end else begin
      trig_d        <= bus.I_DMA_TRIG;
      rd_v          <= 1'b0;
      bus.O_DONE    <= 1'b0;
      bus.O_DMA_CES <= 1'b0;
      bus.O_DMA_CED <= 1'b0;
      if (start && state != IDLE)
        pend <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= REQ;
            bus.O_BUSY <= 1'b1;
            bus.O_HOLD <= 1'b1;
          end
        end
        REQ: begin
          if (bus.I_HLDA) begin
            state         <= RUN;
            rd_idx        <= '0;
            wr_idx        <= '0;
            bus.O_DMA_CES <= 1'b1;
            bus.O_DMA_AS  <= SRC_BASE;
          end
        end
        RUN: begin
          // read k in cycle k, its data lands k+1, written in k+2
          rd_idx <= rd_idx + 1'b1;
          rd_v   <= bus.O_DMA_CES;
          if (rd_idx + 1'b1 < LEN) begin
            bus.O_DMA_CES <= 1'b1;
            bus.O_DMA_AS  <= bus.O_DMA_AS + 1'b1;
          end
          if (rd_v) begin
            bus.O_DMA_CED <= 1'b1;
            bus.O_DMA_AD  <= DST_BASE + wr_idx;
            bus.O_DMA_DD  <= bus.I_DMA_DS;
            wr_idx        <= wr_idx + 1'b1;
          end
          if (rd_idx == LAST) begin
            state      <= DONE;
            bus.O_HOLD <= 1'b0;
            bus.O_DONE <= 1'b1;
          end
        end
        DONE: begin
          if (pend || start) begin
            state      <= REQ;
            pend       <= 1'b0;
            bus.O_HOLD <= 1'b1;
          end else begin
            state      <= IDLE;
            bus.O_BUSY <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef DKONG3_DMA_CSUM_EN
  logic [7:0] acc;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      acc        <= '0;
      bus.O_CSUM <= '0;
    end else if (state == REQ && bus.I_HLDA) begin
      acc <= '0;
    end else if (state == RUN) begin
      if (bus.O_DMA_CED)
        acc <= acc + bus.O_DMA_DD;
      // last write is still in flight on the cycle we publish
      if (rd_idx == LAST)
        bus.O_CSUM <= acc + (bus.O_DMA_CED ? bus.O_DMA_DD : 8'h00);
    end
  end
`endif

endmodule

// File: tb/tb_dkong3_dma_seq.sv
// tb_dkong3_dma_seq: random transfers on a 4-byte and a default-size DMA,
// checked against a per-transfer byte/timing model of expected RAM traffic.
module tb_dkong3_dma_seq;

  typedef struct packed {
    logic [31:0] cyc;
    logic [9:0]  a;
    logic [7:0]  d;
    logic [1:0]  f;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic       rst  [2];
  logic       trig [2];
  logic       hlda [2];
  logic [7:0] ds   [2];
  logic [7:0] mem  [2][1024];
  logic       grant[2];
  int         nogr [2];

  logic       hold[2], busy[2], done[2], ces[2], ced[2];
  logic [9:0] as_[2], ad[2];
  logic [7:0] dd[2];
`ifdef DKONG3_DMA_CSUM_EN
  logic [7:0] csum[2];
`endif

  ev_t rdq[2][$];
  ev_t wrq[2][$];
  ev_t dnq[2][$];

  dkong3_dma_seq_if #(.AW(10)) bs ();
  dkong3_dma_seq_if #(.AW(10)) bd ();

  assign bs.I_DMA_TRIG = trig[0];
  assign bs.I_HLDA     = hlda[0];
  assign bs.I_DMA_DS   = ds[0];
  assign bd.I_DMA_TRIG = trig[1];
  assign bd.I_HLDA     = hlda[1];
  assign bd.I_DMA_DS   = ds[1];

  assign hold[0] = bs.O_HOLD;
  assign busy[0] = bs.O_BUSY;
  assign done[0] = bs.O_DONE;
  assign ces[0]  = bs.O_DMA_CES;
  assign ced[0]  = bs.O_DMA_CED;
  assign as_[0]  = bs.O_DMA_AS;
  assign ad[0]   = bs.O_DMA_AD;
  assign dd[0]   = bs.O_DMA_DD;
  assign hold[1] = bd.O_HOLD;
  assign busy[1] = bd.O_BUSY;
  assign done[1] = bd.O_DONE;
  assign ces[1]  = bd.O_DMA_CES;
  assign ced[1]  = bd.O_DMA_CED;
  assign as_[1]  = bd.O_DMA_AS;
  assign ad[1]   = bd.O_DMA_AD;
  assign dd[1]   = bd.O_DMA_DD;
`ifdef DKONG3_DMA_CSUM_EN
  assign csum[0] = bs.O_CSUM;
  assign csum[1] = bd.O_CSUM;
`endif

  dkong3_dma_seq #(
    .XFER_LEN(4),
    .AW(10),
    .SRC_BASE(10'h010),
    .DST_BASE(10'h020)
  ) u_small (
    .I_CLK(clk),
    .I_RESET(rst[0]),
    .bus(bs.master)
  );

  dkong3_dma_seq u_dflt (
    .I_CLK(clk),
    .I_RESET(rst[1]),
    .bus(bd.master)
  );

  // source RAM: data one clock after the read strobe, junk otherwise
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ces[i] === 1'b1) ds[i] <= mem[i][as_[i]];
      else ds[i] <= 8'($urandom);
      if (hold[i] === 1'b1 && hlda[i] === 1'b1) grant[i] <= 1'b1;
      else if (hold[i] === 1'b0) grant[i] <= 1'b0;
    end
  end

  function automatic ev_t mk(input int c, input logic [9:0] a,
                             input logic [7:0] d, input logic [1:0] f);
    ev_t e;
    e.cyc = 32'(c);
    e.a   = a;
    e.d   = d;
    e.f   = f;
    return e;
  endfunction

  function automatic logic [7:0] cs(input int i);
`ifdef DKONG3_DMA_CSUM_EN
    return csum[i];
`else
    return (i < 0) ? 8'h01 : 8'h00;
`endif
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ces[i] === 1'b1)
        rdq[i].push_back(mk(cyc, as_[i], 8'h00, 2'b00));
      if (ced[i] === 1'b1)
        wrq[i].push_back(mk(cyc, ad[i], dd[i], 2'b00));
      if (done[i] === 1'b1)
        dnq[i].push_back(mk(cyc, 10'h000, cs(i), {hold[i], busy[i]}));
      if (ces[i] === 1'b1 && grant[i] !== 1'b1)
        nogr[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear(input int i);
    rdq[i].delete();
    wrq[i].delete();
    dnq[i].delete();
    nogr[i] = 0;
  endtask

  task automatic rand_mem(input int i);
    for (int a = 0; a < 1024; a++) mem[i][a] = 8'($urandom);
  endtask

  // transfer t must read src+k at s+k and write dst+k at s+k+2
  task automatic check_xfer(input int i, input int t, input int L,
                            input int src, input int dst, input int s);
    int b, ai, ra, rc, wa, wd, wc;
    bit ok;
`ifdef DKONG3_DMA_CSUM_EN
    logic [7:0] sum;
    sum = 8'h00;
`endif
    b  = t * L;
    ra = 0; rc = 0; wa = 0; wd = 0; wc = 0;
    ok = rdq[i].size() >= b + L && wrq[i].size() >= b + L &&
         dnq[i].size() > t;
    check("xfer_avail", 32'(ok), 1);
    if (!ok) return;
    for (int k = 0; k < L; k++) begin
      ai = (src + k) % 1024;
      if (rdq[i][b+k].a != 10'(ai)) ra++;
      if (rdq[i][b+k].cyc != 32'(s + k)) rc++;
      if (wrq[i][b+k].a != 10'((dst + k) % 1024)) wa++;
      if (wrq[i][b+k].d != mem[i][ai]) wd++;
      if (wrq[i][b+k].cyc != 32'(s + k + 2)) wc++;
`ifdef DKONG3_DMA_CSUM_EN
      sum = sum + mem[i][ai];
`endif
    end
    check("rd_addr_errs", ra, 0);
    check("rd_cyc_errs", rc, 0);
    check("wr_addr_errs", wa, 0);
    check("wr_data_errs", wd, 0);
    check("wr_cyc_errs", wc, 0);
    check("done_cyc", dnq[i][t].cyc, 32'(s + L + 2));
    check("done_hold", dnq[i][t].f[1], 0);
    check("done_busy", dnq[i][t].f[0], 1);
`ifdef DKONG3_DMA_CSUM_EN
    check("csum", dnq[i][t].d, sum);
`endif
  endtask

  task automatic xfer(input int i, input int L, input int src,
                      input int dst, input int hd, input bit drop);
    int c, s, w;
    clear(i);
    hlda[i] = (hd == 0);
    trig[i] = 1'b0;
    tick();
    trig[i] = 1'b1;
    c = cyc;
    tick();
    trig[i] = 1'b0;
    if (hd > 0) begin
      repeat (hd - 1) tick();
      hlda[i] = 1'b1;
    end
    s = (hd == 0) ? c + 2 : c + hd + 1;
    w = 0;
    while (dnq[i].size() == 0 && w < L + 40) begin
      tick();
      w++;
      if (drop && w == 3) hlda[i] = 1'b0;
    end
    repeat (4) tick();
    check("n_rd", rdq[i].size(), L);
    check("n_wr", wrq[i].size(), L);
    check("n_done", dnq[i].size(), 1);
    check("ces_in_req", nogr[i], 0);
    check("idle_busy", busy[i], 0);
    check("idle_hold", hold[i], 0);
    check_xfer(i, 0, L, src, dst, s);
  endtask

  task automatic retrig(input int e, input bit third);
    int c, w;
    clear(0);
    rand_mem(0);
    hlda[0] = 1'b1;
    trig[0] = 1'b0;
    tick();
    c = cyc;
    for (int j = 0; j < 10; j++) begin
      trig[0] = (j == 0) || (j == e) || (third && j == e + 2);
      tick();
    end
    trig[0] = 1'b0;
    w = 0;
    while (dnq[0].size() < 2 && w < 60) begin
      tick();
      w++;
    end
    repeat (20) tick();
    check("rt_n_done", dnq[0].size(), 2);
    check("rt_n_wr", wrq[0].size(), 8);
    check("rt_busy", busy[0], 0);
    check_xfer(0, 0, 4, 16, 32, c + 2);
    check_xfer(0, 1, 4, 16, 32, c + 10);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 2; i++) begin
      rst[i]  = 1'b1;
      trig[i] = 1'b0;
      hlda[i] = 1'b0;
      nogr[i] = 0;
    end
    repeat (3) tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rst_ctl", {hold[i], busy[i], done[i], ces[i], ced[i]}, 0);
      check("rst_addr", {as_[i], ad[i]}, 0);
      check("rst_dd", dd[i], 0);
`ifdef DKONG3_DMA_CSUM_EN
      check("rst_csum", csum[i], 0);
`endif
    end

    rand_mem(0);
    mem[0][16] = 8'h11;
    mem[0][17] = 8'h22;
    mem[0][18] = 8'h33;
    mem[0][19] = 8'h44;
    xfer(0, 4, 16, 32, 0, 1'b0);
    check("first_dd", wrq[0].size() > 0 ? wrq[0][0].d : 8'h00, 8'h11);
    check("last_ad", wrq[0].size() > 3 ? wrq[0][3].a : 10'h0, 10'h023);
    check("last_dd", wrq[0].size() > 3 ? wrq[0][3].d : 8'h00, 8'h44);

    mem[0][16] = 8'h80;
    mem[0][17] = 8'h90;
    mem[0][18] = 8'h01;
    mem[0][19] = 8'h02;
    xfer(0, 4, 16, 32, 2, 1'b0);
`ifdef DKONG3_DMA_CSUM_EN
    check("csum_13", dnq[0].size() > 0 ? dnq[0][0].d : 8'h00, 8'h13);
    check("csum_hold", csum[0], 8'h13);
`endif

    rand_mem(1);
    xfer(1, 415, 0, 0, 5, 1'b0);
    check("dflt_last_ad",
          wrq[1].size() > 0 ? wrq[1][wrq[1].size()-1].a : 10'h3FF,
          10'h19E);

    for (int r = 0; r < 8; r++) begin
      rand_mem(0);
      xfer(0, 4, 16, 32, $urandom_range(0, 6),
           1'($urandom_range(0, 1)));
    end

    retrig(3, 1'b1);
    retrig(8, 1'b0);

    // reset during RUN cycle 2 with a retrigger already pending
    clear(0);
    rand_mem(0);
    hlda[0] = 1'b1;
    trig[0] = 1'b0;
    tick();
    trig[0] = 1'b1;
    c = cyc;
    tick();
    trig[0] = 1'b0;
    tick();
    tick();
    trig[0] = 1'b1;
    tick();
    trig[0] = 1'b0;
    rst[0]  = 1'b1;
    tick();
    check("rmid_cyc", cyc, c + 5);
    check("rmid_ctl", {hold[0], busy[0], done[0], ces[0], ced[0]}, 0);
    check("rmid_addr", {as_[0], ad[0]}, 0);
    check("rmid_dd", dd[0], 0);
    rst[0] = 1'b0;
    repeat (15) tick();
    check("rmid_n_rd", rdq[0].size(), 3);
    check("rmid_n_wr", wrq[0].size(), 1);
    check("rmid_n_done", dnq[0].size(), 0);
    check("rmid_busy", busy[0], 0);
    rand_mem(0);
    xfer(0, 4, 16, 32, 1, 1'b0);

    // trigger high across reset release must not start a transfer
    trig[0] = 1'b1;
    rst[0]  = 1'b1;
    repeat (2) tick();
    rst[0] = 1'b0;
    clear(0);
    repeat (10) tick();
    check("thru_busy", busy[0], 0);
    check("thru_n_rd", rdq[0].size(), 0);
    rand_mem(0);
    xfer(0, 4, 16, 32, 0, 1'b0);

    rand_mem(1);
    xfer(1, 415, 0, 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
